game_sequencer: RTL and testbench

// Frame-level game controller between vga640x480 and the square animators.

---
 rtl/game_sequencer.sv | 145 ++++++++++++++
 tb/tb_game_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - IDLE/PLAY/DEAD game FSM with frame gating, scoring and collision latch (optional pause: GAME_SEQ_PAUSE_EN)
module game_sequencer #(
    parameter int DEAD_FRAMES  = 120,
    parameter int SCORE_PERIOD = 60,
    parameter int SCORE_W      = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_animate,
    input  logic               i_flap,
    input  logic               i_hit,
`ifdef GAME_SEQ_PAUSE_EN
    input  logic               i_pause,
`endif
    output logic [1:0]         o_state,
    output logic               o_ani_en,
    output logic               o_obj_rst,
    output logic               o_flap_pulse,
    output logic [SCORE_W-1:0] o_score
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DEAD  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int DW = (DEAD_FRAMES > 1) ? $clog2(DEAD_FRAMES) : 1;
    localparam int FW = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;
    localparam logic [DW-1:0]      DEAD_LAST  = DW'(DEAD_FRAMES - 1);
    localparam logic [FW-1:0]      FRAME_LAST = FW'(SCORE_PERIOD - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t             state, state_nx;
    logic               flap_q;
    logic               hit_q, hit_nx;
    logic [DW-1:0]      dead_cnt, dead_cnt_nx;
    logic [FW-1:0]      frame_cnt, frame_cnt_nx;
    logic [SCORE_W-1:0] score_nx;
    logic               ani_nx, obj_rst_nx, flap_pulse_nx;
    logic               frame_tick, hit_now, flap_rise, pause_rise;

    assign frame_tick = i_animate & i_pix_stb;
    assign hit_now    = i_hit & i_pix_stb;
    assign flap_rise  = i_flap & ~flap_q;

`ifdef GAME_SEQ_PAUSE_EN
    logic pause_q;
    assign pause_rise = i_pause & ~pause_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) pause_q <= 1'b0;
        else          pause_q <= i_pause;
    end
`else
    assign pause_rise = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        dead_cnt_nx   = dead_cnt;
        frame_cnt_nx  = frame_cnt;
        score_nx      = o_score;
        hit_nx        = 1'b0;
        ani_nx        = 1'b0;
        obj_rst_nx    = 1'b0;
        flap_pulse_nx = 1'b0;
        case (state)
            PLAY: begin
                hit_nx = hit_q | hit_now;
                if (frame_tick && (hit_q || hit_now)) begin
                    // collision beats any flap or pause arriving on the same tick
                    state_nx    = DEAD;
                    dead_cnt_nx = '0;
                    hit_nx      = 1'b0;
                end else if (pause_rise) begin
                    state_nx = PAUSE;
                    hit_nx   = 1'b0;
                end else begin
                    flap_pulse_nx = flap_rise;
                    if (frame_tick) begin
                        hit_nx = 1'b0;
                        ani_nx = 1'b1;
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt_nx = '0;
                            if (o_score != SCORE_MAX)
                                score_nx = o_score + 1'b1;
                        end else begin
                            frame_cnt_nx = frame_cnt + 1'b1;
                        end
                    end
                end
            end
            DEAD: begin
                if (frame_tick) begin
                    if (dead_cnt == DEAD_LAST) state_nx = IDLE;
                    else                       dead_cnt_nx = dead_cnt + 1'b1;
                end
            end
`ifdef GAME_SEQ_PAUSE_EN
            PAUSE: begin
                if (pause_rise) state_nx = PLAY;
            end
`endif
            default: begin
                // IDLE; without the pause option the unused code 3 also lands here
                if (flap_rise) begin
                    state_nx     = PLAY;
                    obj_rst_nx   = 1'b1;
                    score_nx     = '0;
                    frame_cnt_nx = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            flap_q       <= 1'b0;
            hit_q        <= 1'b0;
            dead_cnt     <= '0;
            frame_cnt    <= '0;
            o_score      <= '0;
            o_ani_en     <= 1'b0;
            o_obj_rst    <= 1'b0;
            o_flap_pulse <= 1'b0;
        end else begin
            state        <= state_nx;
            flap_q       <= i_flap;
            hit_q        <= hit_nx;
            dead_cnt     <= dead_cnt_nx;
            frame_cnt    <= frame_cnt_nx;
            o_score      <= score_nx;
            o_ani_en     <= ani_nx;
            o_obj_rst    <= obj_rst_nx;
            o_flap_pulse <= flap_pulse_nx;
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - directed scoreboard bench for game_sequencer (pause steps under GAME_SEQ_PAUSE_EN)
module tb_game_sequencer;

    localparam int DEAD_FRAMES  = 120;
    localparam int SCORE_PERIOD = 60;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0, pix = 1'b0, anim = 1'b0, flap = 1'b0, hit = 1'b0;
`ifdef GAME_SEQ_PAUSE_EN
    logic pause = 1'b0;
`endif
    logic [1:0] st, st2;
    logic       ani, ani2, orst, orst2, fp, fp2;
    logic [7:0] score;
    logic [1:0] score2;

    game_sequencer #(.DEAD_FRAMES(DEAD_FRAMES), .SCORE_PERIOD(SCORE_PERIOD), .SCORE_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix), .i_animate(anim), .i_flap(flap), .i_hit(hit),
`ifdef GAME_SEQ_PAUSE_EN
        .i_pause(pause),
`endif
        .o_state(st), .o_ani_en(ani), .o_obj_rst(orst), .o_flap_pulse(fp), .o_score(score));

    game_sequencer #(.DEAD_FRAMES(DEAD_FRAMES), .SCORE_PERIOD(SCORE_PERIOD), .SCORE_W(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix), .i_animate(anim), .i_flap(flap), .i_hit(hit),
`ifdef GAME_SEQ_PAUSE_EN
        .i_pause(pause),
`endif
        .o_state(st2), .o_ani_en(ani2), .o_obj_rst(orst2), .o_flap_pulse(fp2), .o_score(score2));

    int checks = 0;
    int failures = 0;
    logic exp_q[$];

    int   m_state = 0, m_score = 0, m_score2 = 0, m_fc = 0, m_dead = 0;
    logic m_hit = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic a_pix, input logic a_anim, input logic a_hit, input logic a_flap);
        @(negedge clk);
        pix = a_pix; anim = a_anim; hit = a_hit; flap = a_flap;
        @(posedge clk);
        #1;
        pix = 1'b0; anim = 1'b0; hit = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_state"}, st, m_state);
        chk({tag, "_score"}, score, m_score);
        chk({tag, "_score_w2"}, score2, m_score2);
        chk({tag, "_state_w2"}, st2, m_state);
    endtask

    task automatic score_up();
        if (m_fc == SCORE_PERIOD - 1) begin
            m_fc = 0;
            if (m_score < 255) m_score++;
            if (m_score2 < 3) m_score2++;
        end else begin
            m_fc++;
        end
    endtask

    // one frame: hit pixel early in the frame, then the end-of-frame tick
    task automatic frame(input logic hit_mid, input logic hit_tick, input logic flap_tick);
        logic exp_ani, exp_fp, exp_or, rise, e;
        exp_ani = 1'b0; exp_fp = 1'b0; exp_or = 1'b0;
        cyc(1'b1, 1'b0, hit_mid, flap);
        if (m_state == 1 && hit_mid) m_hit = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, flap);
        chk("ani_gap", ani, 1'b0);
        rise = flap_tick & ~flap;
        case (m_state)
            1: begin
                if (m_hit || hit_tick) begin
                    m_state = 2; m_dead = 0;
                end else begin
                    exp_ani = 1'b1;
                    exp_fp  = rise;
                    score_up();
                end
            end
            2: begin
                if (m_dead == DEAD_FRAMES - 1) m_state = 0;
                else m_dead++;
            end
            0: begin
                if (rise) begin
                    m_state = 1; m_score = 0; m_score2 = 0; m_fc = 0; exp_or = 1'b1;
                end
            end
            default: ;
        endcase
        m_hit = 1'b0;
        exp_q.push_back(exp_ani);
        cyc(1'b1, 1'b1, hit_tick, flap_tick);
        e = exp_q.pop_front();
        chk("ani_en", ani, e);
        chk("flap_pulse", fp, exp_fp);
        chk("obj_rst", orst, exp_or);
        check_all("frame");
    endtask

    task automatic flap_press();
        logic exp_or, exp_fp;
        exp_or = 1'b0; exp_fp = 1'b0;
        if (m_state == 0) begin
            m_state = 1; m_score = 0; m_score2 = 0; m_fc = 0; exp_or = 1'b1;
        end else if (m_state == 1) begin
            exp_fp = 1'b1;
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("press_obj_rst", orst, exp_or);
        chk("press_flap_pulse", fp, exp_fp);
        check_all("press");
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("press_obj_rst_1cyc", orst, 1'b0);
        chk("press_flap_1cyc", fp, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        m_state = 0; m_score = 0; m_score2 = 0; m_fc = 0; m_dead = 0; m_hit = 1'b0;
        chk("rst_state", st, 0);
        chk("rst_score", score, 0);
        chk("rst_ani_en", ani, 1'b0);
        chk("rst_obj_rst", orst, 1'b0);
        chk("rst_flap_pulse", fp, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef GAME_SEQ_PAUSE_EN
    task automatic pause_press(input int exp_state);
        @(negedge clk);
        pause = 1'b1;
        @(posedge clk);
        #1;
        m_state = exp_state;
        check_all("pause");
        @(negedge clk);
        pause = 1'b0;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        do_reset();

        flap_press();
        for (int i = 0; i < 10; i++) frame(1'b0, 1'b0, flap);

        for (int i = 0; i < 120; i++) frame(1'b0, 1'b0, flap);
        chk("score_130", score, 8'd2);
        for (int i = 0; i < 170; i++) frame(1'b0, 1'b0, flap);
        chk("score_300", score, 8'd5);
        chk("score_w2_sat", score2, 2'd3);

        flap_press();
        frame(1'b1, 1'b0, flap);
        chk("hit_dead", st, 2'd2);
        flap_press();
        for (int i = 0; i < DEAD_FRAMES - 1; i++) frame(1'b0, 1'b0, flap);
        chk("dead_119", st, 2'd2);
        frame(1'b0, 1'b0, flap);
        chk("dead_done", st, 2'd0);
        chk("dead_score_kept", score, 8'd5);

        flap_press();
        for (int i = 0; i < 3; i++) frame(1'b0, 1'b0, flap);
        frame(1'b0, 1'b1, 1'b1);
        chk("flap_hit_dead", st, 2'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        frame(1'b0, 1'b0, 1'b1);
        frame(1'b0, 1'b0, flap);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef GAME_SEQ_PAUSE_EN
        pause_press(3);
        for (int i = 0; i < 50; i++) frame(1'b1, 1'b0, flap);
        pause_press(1);
        frame(1'b0, 1'b0, flap);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
